// File: rtl/acc_pkg.sv
// Shared op codes and default widths for the accumulator unit.
package acc_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } acc_op_t;

endpackage

// File: rtl/acc_sat_add.sv
// Combinational WIDTH+1 signed add/sub with overflow detect and optional clamp.
module acc_sat_add #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             sub,
  output logic [WIDTH-1:0] result_c,
  output logic             pos_ovf_c,
  output logic             neg_ovf_c
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] acc_x;
  logic [SUM_W-1:0] opd_x;
  logic [SUM_W-1:0] sum;

  // One guard bit makes every overflow, including negating the most-negative operand, visible.
  always_comb begin
    acc_x     = {acc[WIDTH-1], acc};
    opd_x     = {operand[WIDTH-1], operand};
    sum       = sub ? SUM_W'(acc_x - opd_x) : SUM_W'(acc_x + opd_x);
    pos_ovf_c = ~sum[WIDTH] & sum[WIDTH-1];
    neg_ovf_c = sum[WIDTH] & ~sum[WIDTH-1];
    result_c  = sum[WIDTH-1:0];
    if (SATURATE && pos_ovf_c) result_c = {1'b0, {(WIDTH-1){1'b1}}};
    if (SATURATE && neg_ovf_c) result_c = {1'b1, {(WIDTH-1){1'b0}}};
  end

endmodule

// File: rtl/acc_unit.sv
// Signed accumulator with load/add/sub/clear, sticky overflow and batch counter.
module acc_unit
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH     = ACC_WIDTH_DEF,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_en,
  input  acc_op_t              op,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [CNT_WIDTH-1:0] batch_len,
  input  logic                 clr_flags,
  output logic [WIDTH-1:0]     Acc_out,
  output logic                 acc_valid,
  output logic                 ovf_flag,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 batch_done
);

  logic [WIDTH-1:0]     arith_res;
  logic                 pos_ovf;
  logic                 neg_ovf;
  logic [WIDTH-1:0]     acc_d;
  logic                 ovf_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 batch_hit;
  logic                 done_d;

  acc_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc       (Acc_out),
    .operand   (data_in),
    .sub       (op == OP_SUB),
    .result_c  (arith_res),
    .pos_ovf_c (pos_ovf),
    .neg_ovf_c (neg_ovf)
  );

  // Next-state: a flag set from an overflowing op wins over clr_flags in the same cycle.
  always_comb begin
    acc_d     = Acc_out;
    cnt_d     = op_count;
    ovf_d     = ovf_flag & ~clr_flags;
    done_d    = 1'b0;
    cnt_inc   = CNT_WIDTH'(op_count + CNT_WIDTH'(1));
    batch_hit = (batch_len != '0) && (cnt_inc == batch_len);
    if (w_en) begin
      case (op)
        OP_LOAD: begin
          acc_d = data_in;
          cnt_d = '0;
        end
        OP_ADD, OP_SUB: begin
          acc_d  = arith_res;
          cnt_d  = batch_hit ? '0 : cnt_inc;
          done_d = batch_hit;
          if (pos_ovf || neg_ovf) ovf_d = 1'b1;
        end
        OP_CLR: begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
        default: begin
          acc_d = Acc_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Acc_out    <= '0;
      acc_valid  <= 1'b0;
      ovf_flag   <= 1'b0;
      op_count   <= '0;
      batch_done <= 1'b0;
    end else begin
      Acc_out    <= acc_d;
      acc_valid  <= w_en;
      ovf_flag   <= ovf_d;
      op_count   <= cnt_d;
      batch_done <= done_d;
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Randomized and directed checks of three acc_unit flavours against an arithmetic model.
module tb_acc_unit;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_en = 1'b0;
  logic        clr_flags = 1'b0;
  acc_op_t     op = OP_LOAD;
  logic [31:0] data_in = '0;
  logic [7:0]  batch_len = '0;

  logic [31:0] acc32;
  logic [7:0]  acc8s, acc8w;
  logic        vld [3];
  logic        ovf [3];
  logic        done [3];
  logic [7:0]  cnt [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Model: 0 = 32-bit saturating, 1 = 8-bit saturating, 2 = 8-bit wrapping
  int unsigned MW   [3] = '{32, 8, 8};
  bit          MSAT [3] = '{1'b1, 1'b1, 1'b0};
  longint      m_acc [3];
  bit          m_vld [3];
  bit          m_ovf [3];
  bit          m_done [3];
  int          m_cnt [3];

  acc_unit #(.WIDTH(32), .SATURATE(1'b1), .CNT_WIDTH(8)) u32 (
    .clk(clk), .reset(reset), .w_en(w_en), .op(op), .data_in(data_in),
    .batch_len(batch_len), .clr_flags(clr_flags), .Acc_out(acc32),
    .acc_valid(vld[0]), .ovf_flag(ovf[0]), .op_count(cnt[0]), .batch_done(done[0]));

  acc_unit #(.WIDTH(8), .SATURATE(1'b1), .CNT_WIDTH(8)) u8s (
    .clk(clk), .reset(reset), .w_en(w_en), .op(op), .data_in(data_in[7:0]),
    .batch_len(batch_len), .clr_flags(clr_flags), .Acc_out(acc8s),
    .acc_valid(vld[1]), .ovf_flag(ovf[1]), .op_count(cnt[1]), .batch_done(done[1]));

  acc_unit #(.WIDTH(8), .SATURATE(1'b0), .CNT_WIDTH(8)) u8w (
    .clk(clk), .reset(reset), .w_en(w_en), .op(op), .data_in(data_in[7:0]),
    .batch_len(batch_len), .clr_flags(clr_flags), .Acc_out(acc8w),
    .acc_valid(vld[2]), .ovf_flag(ovf[2]), .op_count(cnt[2]), .batch_done(done[2]));

  always #5 clk = ~clk;

  // Reduce any integer into the signed range of a w-bit register
  function automatic longint wrap(int unsigned w, longint s);
    longint m;
    m = s & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic longint dut_acc(int i);
    if (i == 0) return longint'($signed(acc32));
    if (i == 1) return longint'($signed(acc8s));
    return longint'($signed(acc8w));
  endfunction

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_vld[i] = 1'b0; m_ovf[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_step(int i);
    longint hi, lo, d, s;
    hi = (64'sd1 <<< (MW[i] - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (MW[i] - 1));
    d  = wrap(MW[i], longint'(data_in));
    m_vld[i]  = w_en;
    m_done[i] = 1'b0;
    if (clr_flags) m_ovf[i] = 1'b0;
    if (w_en) begin
      if (op == OP_LOAD) begin
        m_acc[i] = d; m_cnt[i] = 0;
      end else if (op == OP_CLR) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end else begin
        s = (op == OP_ADD) ? m_acc[i] + d : m_acc[i] - d;
        if (s > hi || s < lo) begin
          m_ovf[i] = 1'b1;
          if (MSAT[i]) m_acc[i] = (s > hi) ? hi : lo;
          else         m_acc[i] = wrap(MW[i], s);
        end else begin
          m_acc[i] = s;
        end
        if (batch_len != 0 && m_cnt[i] + 1 == int'(batch_len)) begin
          m_done[i] = 1'b1; m_cnt[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % 256;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("acc[%0d]", i), dut_acc(i), m_acc[i]);
        check($sformatf("valid[%0d]", i), longint'(vld[i]), longint'(m_vld[i]));
        check($sformatf("ovf[%0d]", i), longint'(ovf[i]), longint'(m_ovf[i]));
        check($sformatf("count[%0d]", i), longint'(cnt[i]), longint'(m_cnt[i]));
        check($sformatf("done[%0d]", i), longint'(done[i]), longint'(m_done[i]));
      end
    end
  end

  task automatic step(input bit we, input acc_op_t o, input logic [31:0] d,
                      input logic [7:0] bl, input bit cf, input bit rst_pulse);
    w_en = we; op = o; data_in = d; batch_len = bl; clr_flags = cf;
    if (rst_pulse) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [31:0] d;
    #1 reset = 1'b1;
    #1 started = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_acc", dut_acc(0), 0);
    check("rst_valid", longint'(vld[0]), 0);
    reset = 1'b0;

    // Async reset between edges, with an overflow already latched on the 8-bit units
    step(1, OP_LOAD, 32'd127, 8'd0, 0, 0);
    step(1, OP_ADD,  32'd1,   8'd0, 0, 0);
    step(1, OP_LOAD, 32'd5,   8'd0, 0, 0);
    step(1, OP_ADD,  32'd3,   8'd0, 0, 0);
    check("pre_rst_acc", dut_acc(0), 8);
    check("pre_rst_ovf", longint'(ovf[1]), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_acc", dut_acc(0), 0);
    check("mid_rst_cnt", longint'(cnt[0]), 0);
    check("mid_rst_ovf", longint'(ovf[1]), 0);
    step(0, OP_LOAD, 32'd0, 8'd0, 0, 0);
    reset = 1'b0;

    // Basic load/add/sub with valid pulse count
    pulses = 0;
    step(1, OP_LOAD, 32'd100, 8'd0, 0, 0); pulses += int'(vld[0]);
    step(1, OP_ADD,  32'd23,  8'd0, 0, 0); pulses += int'(vld[0]);
    step(1, OP_SUB,  32'd50,  8'd0, 0, 0); pulses += int'(vld[0]);
    check("basic_acc", dut_acc(0), 73);
    check("basic_cnt", longint'(cnt[0]), 2);
    step(0, OP_ADD, 32'd9, 8'd0, 0, 0); pulses += int'(vld[0]);
    check("basic_valid_pulses", pulses, 3);
    check("basic_hold", dut_acc(0), 73);

    // Saturation and wrap at 8 bits
    step(1, OP_LOAD, 32'd120, 8'd0, 0, 0);
    step(1, OP_ADD,  32'd10,  8'd0, 0, 0);
    check("sat_pos_acc", dut_acc(1), 127);
    check("sat_pos_ovf", longint'(ovf[1]), 1);
    check("wrap_pos_acc", dut_acc(2), -126);
    step(1, OP_LOAD, 32'hFFFF_FF88, 8'd0, 0, 0);
    step(1, OP_SUB,  32'd10, 8'd0, 0, 0);
    check("sat_neg_acc", dut_acc(1), -128);
    check("sat_neg_ovf", longint'(ovf[1]), 1);
    check("wide_neg_acc", dut_acc(0), -130);
    step(1, OP_CLR, 32'd0, 8'd0, 0, 0);
    check("clr_ovf", longint'(ovf[1]), 0);
    step(1, OP_LOAD, 32'd127, 8'd0, 0, 0);
    step(1, OP_ADD,  32'd1,   8'd0, 0, 0);
    check("wrap_acc", dut_acc(2), -128);
    check("wrap_ovf", longint'(ovf[2]), 1);
    step(0, OP_LOAD, 32'd0, 8'd0, 1, 0);
    check("clr_flags_ovf", longint'(ovf[2]), 0);

    // Batch of four with an idle gap
    step(1, OP_CLR, 32'd0, 8'd4, 0, 0);
    pulses = 0;
    step(1, OP_ADD, 32'd1, 8'd4, 0, 0); pulses += int'(done[0]);
    step(1, OP_ADD, 32'd1, 8'd4, 0, 0); pulses += int'(done[0]);
    step(0, OP_ADD, 32'd1, 8'd4, 0, 0); pulses += int'(done[0]);
    step(1, OP_ADD, 32'd1, 8'd4, 0, 0); pulses += int'(done[0]);
    step(1, OP_ADD, 32'd1, 8'd4, 0, 0);
    check("batch_done", longint'(done[0]), 1);
    check("batch_cnt", longint'(cnt[0]), 0);
    check("batch_acc", dut_acc(0), 4);
    step(0, OP_ADD, 32'd1, 8'd4, 0, 0); pulses += int'(done[0]);
    check("batch_early_pulses", pulses, 0);

    // Unbounded batch: counter wraps, no pulses
    step(1, OP_CLR, 32'd0, 8'd0, 0, 0);
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      step(1, OP_ADD, 32'd1, 8'd0, 0, 0);
      pulses += int'(done[0]);
    end
    check("nobatch_cnt", longint'(cnt[0]), 44);
    check("nobatch_pulses", pulses, 0);
    check("nobatch_acc", dut_acc(0), 300);

    // Set beats clear; idle ignores op/data
    step(0, OP_LOAD, 32'd0, 8'd0, 1, 0);
    step(1, OP_LOAD, 32'd120, 8'd0, 0, 0);
    step(1, OP_ADD,  32'd10,  8'd0, 1, 0);
    check("set_wins_ovf", longint'(ovf[1]), 1);
    for (int k = 0; k < 4; k++) begin
      step(0, OP_CLR, $urandom, 8'd0, 0, 0);
      check("idle_acc", dut_acc(1), 127);
      check("idle_valid", longint'(vld[1]), 0);
    end

    // Randomized traffic with occasional async reset
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 5))
        0: d = $urandom;
        1: d = 32'h0000_007F;
        2: d = 32'h0000_0080;
        3: d = 32'h7FFF_FFFF;
        4: d = 32'h8000_0000;
        default: d = 32'($urandom_range(0, 20));
      endcase
      step($urandom_range(0, 3) != 0, acc_op_t'($urandom_range(0, 3)), d,
           8'($urandom_range(0, 6)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
Name: acc_unit

Overview:
- Parametrised signed accumulator; next generation of the fixed 32-bit write-enabled accumulator.
- Adds the following over that block:
  - configurable width;
  - an operation select (load/add/sub/clear);
  - selectable saturating or wrapping arithmetic;
  - a sticky overflow flag;
  - an operation counter with batch-complete pulse;
  - a registered result-valid strobe.
- Sits in the datapath wherever running sums/MAC tails are needed; consumed by downstream register/bus logic.

Parameters:
- WIDTH, 32, accumulator and data-input width in bits (two's-complement signed), ≥ 2.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH.
- CNT_WIDTH, 8, width of operation counter and batch_len.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- w_en  input  1  operation strobe; op/data_in sampled on rising clk when high.
- op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- data_in  input  WIDTH  signed operand.
- batch_len  input  CNT_WIDTH  number of ADD/SUB ops per batch; 0 disables batch_done.
- clr_flags  input  1  clears ovf_flag (synchronous).
- Acc_out  output  WIDTH  current accumulator value (registered).
- acc_valid  output  1  one-cycle pulse, high the cycle after any accepted op.
- ovf_flag  output  1  sticky overflow indicator.
- op_count  output  CNT_WIDTH  ADD/SUB ops accepted since last LOAD/CLEAR/batch wrap.
- batch_done  output  1  one-cycle pulse when op_count reaches batch_len.

Behaviour:
- Reset (async, any time, incl. mid-batch):
  - Acc_out = 0, acc_valid = 0, ovf_flag = 0, op_count = 0, batch_done = 0.
  - Takes effect immediately.
  - First op accepted on the first rising edge after reset deasserts.
- w_en = 0:
  - All state holds.
  - acc_valid = 0, batch_done = 0.
  - op/data_in are don't-care.
- Latency: an op sampled at edge N is visible on Acc_out/flags after edge N; acc_valid is high for exactly the cycle following edge N.
- LOAD:
  - Acc_out ← data_in, op_count ← 0.
  - ovf_flag unchanged.
- CLEAR:
  - Acc_out ← 0, op_count ← 0, ovf_flag ← 0.
- ADD/SUB arithmetic:
  - Compute at WIDTH+1 bits: sum = Acc_out ± data_in (both sign-extended).
  - Overflow when bits [WIDTH] and [WIDTH-1] of the sum differ.
- ADD/SUB with no overflow: Acc_out ← sum[WIDTH-1:0].
- ADD/SUB with overflow:
  - ovf_flag ← 1.
  - SATURATE=1: Acc_out ← 2^(WIDTH-1)-1 on positive overflow, ← -2^(WIDTH-1) on negative overflow.
  - SATURATE=0: Acc_out ← sum[WIDTH-1:0] (wrap).
- SUB of the most-negative operand is handled by the WIDTH+1 arithmetic; no special case.
- ADD/SUB counting:
  - op_count increments by 1.
  - If batch_len ≠ 0 and op_count+1 == batch_len: batch_done pulses the next cycle and op_count ← 0 (Acc_out not cleared).
  - If batch_len = 0: op_count wraps at 2^CNT_WIDTH; batch_done never asserts.
- batch_len:
  - Sampled every accepted ADD/SUB.
  - Changing it mid-batch takes effect on the next op.
  - If op_count already ≥ new batch_len, no pulse until counter wraps.
- clr_flags:
  - clr_flags and an overflowing op in the same cycle: set wins (ovf_flag = 1).
  - clr_flags with CLEAR: ovf_flag = 0.
- op encodings are exhaustive; no illegal op.

Decomposition:
- Shared package acc_pkg holds:
  - op codes OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_CLR=2'b11;
  - a 2-bit acc_op_t typedef.
- One natural sub-module, acc_sat_add: combinational WIDTH+1 add/sub producing the result and pos_ovf/neg_ovf, with SATURATE as parameter.
- Counter and flag logic stay in acc_unit.

Test Plan:
- Reset mid-run: LOAD 5, ADD 3, assert reset between edges → Acc_out = 0, op_count = 0, ovf_flag = 0 immediately, before the next edge.
- WIDTH=32: LOAD 100, ADD 23, SUB 50 → Acc_out = 73 after the third op; acc_valid high exactly 3 cycles; op_count = 2.
- WIDTH=8, SATURATE=1: LOAD 120, ADD 10 → Acc_out = 127, ovf_flag = 1. Then LOAD -120, SUB 10 → Acc_out = -128, ovf_flag still 1. Then CLEAR → ovf_flag = 0.
- WIDTH=8, SATURATE=0: LOAD 127, ADD 1 → Acc_out = -128 (8'h80), ovf_flag = 1. Then clr_flags with no op → ovf_flag = 0.
- Batch: batch_len = 4, four ADD 1 with a w_en=0 gap between ops 2 and 3 → batch_done single pulse after the 4th op; op_count = 0; Acc_out = 4. batch_len = 0, 300 ADDs (CNT_WIDTH=8) → op_count = 44, no batch_done.
- Simultaneous events, WIDTH=8 SATURATE=1: clr_flags with overflowing ADD → ovf_flag = 1. w_en=0 with op=CLEAR and data_in toggling → Acc_out unchanged, acc_valid = 0.
